// File: rtl/layer1_fmap_collector.sv
// layer1_fmap_collector: captures one frame of six 14x14 signed pixels from the
// layer-1 output stream (one raster-order beat per in_valid). Once the frame is
// complete, it serves registered single-pixel reads until the frame is released.
//
// Ports:
//   clk, rst_n (synchronous, active-high despite the name), en (global enable)
//   in_valid, in1..in6       : input beat, channels 0..5, same (row,col)
//   collecting, map_ready    : state is COLLECT / FULL
//   wr_count, overflow       : beats accepted so far, sticky beat-while-FULL flag
//   rd_req, rd_ch/row/col    : read request, honoured only while FULL
//   rd_data, rd_valid, rd_err: read result, one cycle after the request
//   frame_release            : consumer is done with the frame. The port is not
//                              called "release" because that is a reserved word.
module layer1_fmap_collector #(
  parameter int DATA_W = 8,
  parameter int MAP_W  = 14,
  parameter int MAP_H  = 14,
  parameter int N_CH   = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in1,
  input  logic signed [DATA_W-1:0] in2,
  input  logic signed [DATA_W-1:0] in3,
  input  logic signed [DATA_W-1:0] in4,
  input  logic signed [DATA_W-1:0] in5,
  input  logic signed [DATA_W-1:0] in6,
  output logic                     collecting,
  output logic                     map_ready,
  output logic [7:0]               wr_count,
  output logic                     overflow,
  input  logic                     rd_req,
  input  logic [2:0]               rd_ch,
  input  logic [3:0]               rd_row,
  input  logic [3:0]               rd_col,
  output logic signed [DATA_W-1:0] rd_data,
  output logic                     rd_valid,
  output logic                     rd_err,
  input  logic                     frame_release
);

  localparam int DEPTH = MAP_W * MAP_H;
  localparam logic [2:0] CH_LIM    = 3'(N_CH);
  localparam logic [3:0] ROW_LIM   = 4'(MAP_H);
  localparam logic [3:0] COL_LIM   = 4'(MAP_W);
  localparam logic [7:0] LAST_ADDR = 8'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;
  state_t state;

  // Frame storage. It is never cleared. A new frame simply overwrites the old one.
  logic signed [DATA_W-1:0] mem [N_CH][DEPTH];
  logic signed [DATA_W-1:0] in_pix [N_CH];

  assign in_pix[0] = in1;
  assign in_pix[1] = in2;
  assign in_pix[2] = in3;
  assign in_pix[3] = in4;
  assign in_pix[4] = in5;
  assign in_pix[5] = in6;

  logic [7:0] rd_addr;
  logic       rd_in_range;
  logic       wr_en;

  assign rd_addr     = 8'(rd_row) * 8'(MAP_W) + 8'(rd_col);
  assign rd_in_range = (rd_ch < CH_LIM) && (rd_row < ROW_LIM) && (rd_col < COL_LIM);

  // wr_count is 0 in IDLE, so one expression covers the first beat and all later beats.
  assign wr_en = !rst_n && en && in_valid && (state != FULL);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int c = 0; c < N_CH; c++) begin
        mem[c][wr_count] <= in_pix[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state    <= IDLE;
      wr_count <= '0;
      overflow <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      // Read strobes are single-cycle pulses. They also drop while en is low.
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      if (en) begin
        case (state)
          IDLE: begin
            if (in_valid) begin
              wr_count <= 8'd1;
              state    <= COLLECT;
            end
          end
          COLLECT: begin
            if (in_valid) begin
              wr_count <= wr_count + 8'd1;
              if (wr_count == LAST_ADDR) state <= FULL;
            end
          end
          FULL: begin
            if (in_valid) overflow <= 1'b1;
            if (rd_req) begin
              if (rd_in_range) begin
                rd_data  <= mem[rd_ch][rd_addr];
                rd_valid <= 1'b1;
              end else begin
                rd_data <= '0;
                rd_err  <= 1'b1;
              end
            end
            // The release comes last, so it wins over an overflow in the same
            // cycle. A read in that cycle is still served from this frame.
            if (frame_release) begin
              state    <= IDLE;
              wr_count <= '0;
              overflow <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign collecting = (state == COLLECT);
  assign map_ready  = (state == FULL);

endmodule
